// File: rtl/mod_pkg.sv
// Shared constants for the repeated-subtraction modulo unit: controller state
// encodings and error codes.
package mod_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] SUB   = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_DIV0  = 2'b01;
  localparam logic [1:0] ERR_LIMIT = 2'b10;

endpackage

// File: rtl/mod_ctrl_if.sv
// Start/busy/done handshake between the issuing unit (master) and the modulo
// sequencer (slave), including abort reporting.
interface mod_ctrl_if;

  logic       start;
  logic       b_zero;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  modport master (
    output start, b_zero,
    input  busy, done, error, err_code
  );

  modport slave (
    input  start, b_zero,
    output busy, done, error, err_code
  );

endinterface

// File: rtl/mod_ctrl.sv
// Sequencing FSM for the repeated-subtraction modulo datapath (a mod b).
// Optional quotient output enabled by defining MOD_CTRL_QUOTIENT_EN.
module mod_ctrl
  import mod_pkg::*;
#(
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned MAX_ITER = 1024
) (
  input  logic             CLK,
  input  logic             RST_N,
  mod_ctrl_if.slave        hs,
  input  logic             less_than,
  output logic             select,
  output logic             write_enable,
  output logic             result_enable
`ifdef MOD_CTRL_QUOTIENT_EN
  ,
  output logic [CNT_W-1:0] quotient
`endif
);

  localparam logic [CNT_W-1:0] ITER_LIM = CNT_W'(MAX_ITER);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] iter;
  logic [1:0]       err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs.start) state_nxt = hs.b_zero ? ERR : LOAD;
      LOAD:    state_nxt = CHECK;
      CHECK: begin
        if (less_than)             state_nxt = WRITE;
        else if (iter == ITER_LIM) state_nxt = ERR;
        else                       state_nxt = SUB;
      end
      SUB:     state_nxt = CHECK;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      iter  <= '0;
      err_q <= ERR_NONE;
    end else begin
      state <= state_nxt;
      if (state == LOAD)     iter <= '0;
      else if (state == SUB) iter <= iter + 1'b1;
      // err_code is sticky: only an accepted start or a new abort changes it
      if (state == IDLE && hs.start)
        err_q <= hs.b_zero ? ERR_DIV0 : ERR_NONE;
      else if (state == CHECK && state_nxt == ERR)
        err_q <= ERR_LIMIT;
    end
  end

`ifdef MOD_CTRL_QUOTIENT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      quotient <= '0;
    else if (state == CHECK && state_nxt == WRITE)
      quotient <= iter;
    else if (state_nxt == ERR)
      quotient <= '0;
  end
`endif

  // Moore outputs: decoded from the state register only
  always_comb begin
    write_enable  = (state == LOAD) || (state == SUB);
    select        = (state == SUB);
    result_enable = (state == WRITE);
  end

  assign hs.busy     = (state != IDLE);
  assign hs.done     = (state == DONE);
  assign hs.error    = (state == ERR);
  assign hs.err_code = err_q;

endmodule
